// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;

    // Per-request flags captured at accept and consumed in FIX.
    typedef struct packed {
        logic is_rem;
        logic neg_q;
        logic neg_r;
        logic dz;
        logic ovf;
    } req_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    logic           borrow;

    assign sh    = {rem_in, quo_in[WIDTH-1]};
    assign trial = sh - {1'b0, divisor};
    // With rem < divisor, sh < 2*divisor, so a non-borrowing trial always fits in WIDTH bits
    // and a wrapped one always has its top bit set.
    assign borrow  = trial[WIDTH];
    assign rem_out = borrow ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/div32_seq.sv
// Iterative DIV/DIVU/REM/REMU unit with valid/ready handshake on both sides.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow resolve at accept.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, nxt;
    req_t             req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, xraw;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    logic             signed_op, is_rem_in, dz_in, ovf_in, special_in, accept;
    logic [WIDTH-1:0] ax, ay, special_f, q_fix, r_fix, fix_f;

    assign signed_op  = (op_t'(op) == OP_DIV) || (op_t'(op) == OP_REM);
    assign is_rem_in  = (op_t'(op) == OP_REM) || (op_t'(op) == OP_REMU);
    assign ax         = (signed_op && x[WIDTH-1]) ? -x : x;
    assign ay         = (signed_op && y[WIDTH-1]) ? -y : y;
    assign dz_in      = (y == '0);
    assign ovf_in     = signed_op && (x == SMIN) && (y == '1);
    assign special_in = dz_in || ovf_in;
    assign special_f  = dz_in ? (is_rem_in ? x : '1) : (is_rem_in ? '0 : SMIN);

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    assign q_fix = req.neg_q ? -quo : quo;
    assign r_fix = req.neg_r ? -rem : rem;

    always_comb begin
        fix_f = req.is_rem ? r_fix : q_fix;
        if (req.dz)
            fix_f = req.is_rem ? xraw : '1;
        else if (req.ovf)
            fix_f = req.is_rem ? '0 : SMIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
`ifdef DIV_EARLY_OUT_EN
                    nxt = special_in ? DONE : CALC;
`else
                    nxt = CALC;
`endif
                end
                CALC: if (cnt == CW'(1)) nxt = FIX;
                FIX:  nxt = DONE;
                DONE: if (out_ready) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req  <= '0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            xraw <= '0;
            f    <= '0;
            dz   <= 1'b0;
        end else if (accept) begin
            req.is_rem <= is_rem_in;
            req.neg_q  <= signed_op && (x[WIDTH-1] ^ y[WIDTH-1]);
            req.neg_r  <= signed_op && x[WIDTH-1];
            req.dz     <= dz_in;
            req.ovf    <= ovf_in;
            cnt        <= CW'(WIDTH);
            rem        <= '0;
            quo        <= ax;
            dvs        <= ay;
            xraw       <= x;
`ifdef DIV_EARLY_OUT_EN
            if (special_in) begin
                f  <= special_f;
                dz <= dz_in;
            end
`endif
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - CW'(1);
        end else if (state == FIX) begin
            f  <= fix_f;
            dz <= req.dz;
        end
    end

`ifndef DIV_EARLY_OUT_EN
    // special_f only feeds the early-out load; keep it observed in the default build.
    logic unused_special;
    assign unused_special = ^{special_in, special_f};
`endif
endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: randomized and directed requests against an arithmetic model.
module tb_div32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] x = '0, y = '0;
    logic        in_ready, out_valid, dz;
    logic [31:0] f;

    div32_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .x(x), .y(y), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .dz(dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] f;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0, errs = 0;
    bit   hold = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic plus the architectural corner cases.
    function automatic logic [32:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit sgn, rm;
        int sa, sb_;
        sgn = (o == 2'b00) || (o == 2'b10);
        rm  = o[1];
        if (b == 0) return {1'b1, rm ? a : 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b0, rm ? 32'h0 : 32'h8000_0000};
        if (sgn) begin
            sa = a; sb_ = b;
            return {1'b0, rm ? 32'(sa % sb_) : 32'(sa / sb_)};
        end
        return {1'b0, rm ? (a % b) : (a / b)};
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit   ok = 1'b0;
        exp_t e;
        logic [32:0] r;
        r = ref_div(o, a, b);
        @(negedge clk);
        op = o; x = a; y = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready && !flush) begin
                @(posedge clk); #1;
                e.f = r[31:0]; e.dz = r[32]; e.acc = cyc;
                e.lat = (EARLY && is_special(o, a, b)) ? 1 : 33;
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        x = $urandom; y = $urandom;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
        @(negedge clk);
    endtask

    // Monitor: drives out_ready, checks latency, hold stability and results on consumption.
    initial begin : monitor
        bit          prev_ov = 1'b0;
        logic [31:0] last_f = '0;
        logic        last_dz = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0; out_ready = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("spurious_out_valid", 1, 0);
                    else check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    check("in_ready_in_done", 64'(in_ready), 0);
                end else if (out_valid && prev_ov) begin
                    check("held_result", {31'b0, dz, f}, {31'b0, last_dz, last_f});
                    if (in_ready) check("in_ready_in_done", 64'(in_ready), 0);
                end
                out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", {31'b0, dz, f}, {31'b0, e.dz, e.f});
                end
                prev_ov = out_valid; last_f = f; last_dz = dz;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          n;

        #1;
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_f", 64'(f), 0);
        check("rst_dz", 64'(dz), 0);
        @(negedge clk); rst = 1'b0;

        do_op(2'b01, 100, 7);
        do_op(2'b11, 100, 7);
        do_op(2'b00, 32'hFFFF_FFF9, 2);
        do_op(2'b10, 32'hFFFF_FFF9, 2);
        do_op(2'b01, 32'h1234, 0);
        do_op(2'b11, 32'h1234, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b00, 32'hFFFF_FF00, 0);
        do_op(2'b10, 32'hFFFF_FF00, 0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
        drain();

        // Result held with out_ready low: output must stay put and no new accept.
        hold = 1'b1;
        do_op(2'b01, 50, 5);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("hold_reached_done", 64'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 1);
            check("hold_in_ready", 64'(in_ready), 0);
        end
        hold = 1'b0;
        do_op(2'b00, 32'hFFFF_FF9C, 7);
        drain();

        // Flush mid-calculation, then flush racing a request in IDLE.
        do_op(2'b01, 1000, 3);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flush_in_ready", 64'(in_ready), 1);
        check("flush_out_valid", 64'(out_valid), 0);
        void'(sb.pop_back());
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; op = 2'b01; x = 8; y = 2;
        @(posedge clk); #1;
        check("flush_beats_accept", 64'(in_ready), 1);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-calculation.
        do_op(2'b01, 12345, 7);
        repeat (19) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 1);
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_f", 64'(f), 0);
        check("arst_dz", 64'(dz), 0);
        void'(sb.pop_back());
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        do_op(2'b01, 9, 3);
        drain();

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       rx = 32'h8000_0000;
                1:       rx = $urandom_range(0, 255);
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       ry = 0;
                1:       ry = 32'hFFFF_FFFF;
                2, 3:    ry = $urandom_range(1, 17);
                4:       ry = -($urandom_range(1, 17));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
